// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the UART boot loader.
package boot_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int TO_W           = 32;
  localparam int WC_W           = 16;

  typedef logic [1:0] state_t;
  localparam state_t S_HDR  = 2'd0;
  localparam state_t S_BODY = 2'd1;
  localparam state_t S_DONE = 2'd2;
  localparam state_t S_ERR  = 2'd3;
endpackage

// File: rtl/uart_boot_loader_word_packer.sv
// Assembles UART bytes MSB-first into 32-bit words; word_valid is combinational
// on the strobe that delivers the last byte so the top can register the write.
module word_packer
  import boot_pkg::*;
(
  input  logic        sysclk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [1:0]  byte_idx
);
  logic [23:0] acc;

  assign word_valid = en && rx_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign word       = {acc, rx_data};

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      byte_idx <= '0;
    end else if (en && rx_valid) begin
      acc      <= {acc[15:0], rx_data};
      byte_idx <= byte_idx + 2'd1;
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed word frame from the UART into data memory, then
// hands the memory port to the CPU and releases it from reset.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_run,
  output logic        load_err
);
  state_t            state;
  logic [WC_W-1:0]   wcnt, n_words, wcnt_nx;
  logic [TO_W-1:0]   to_cnt;
  logic              lw_we, run_q;
  logic [31:0]       lw_addr, lw_wdata;
  logic              pk_en, word_valid, hdr_bad, to_run, timeout_hit;
  logic [31:0]       word;
  logic [1:0]        byte_idx;

  assign pk_en = (state == S_HDR) || (state == S_BODY);

  word_packer u_packer (
    .sysclk     (sysclk),
    .rst        (rst),
    .en         (pk_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .word_valid (word_valid),
    .word       (word),
    .byte_idx   (byte_idx)
  );

  assign wcnt_nx     = wcnt + 1'b1;
  assign hdr_bad     = (word[31:16] != '0) || (word[15:0] > WC_W'(MAX_WORDS));
  assign to_run      = (state == S_BODY) || ((state == S_HDR) && (byte_idx != 2'd0));
  // A strobe in the same cycle as expiry keeps the load alive.
  assign timeout_hit = to_run && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state    <= S_HDR;
      wcnt     <= '0;
      n_words  <= '0;
      to_cnt   <= '0;
      lw_we    <= 1'b0;
      lw_addr  <= '0;
      lw_wdata <= '0;
      run_q    <= 1'b0;
    end else begin
      lw_we <= 1'b0;
      // run lags S_DONE by one cycle so the final loader write reaches memory.
      run_q <= (state == S_DONE);
      if (rx_valid)    to_cnt <= '0;
      else if (to_run) to_cnt <= to_cnt + 1'b1;

      if (timeout_hit) begin
        state <= S_ERR;
      end else if (word_valid) begin
        case (state)
          S_HDR: begin
            if (hdr_bad) begin
              state <= S_ERR;
            end else begin
              lw_we    <= 1'b1;
              lw_addr  <= BASE_ADDR;
              lw_wdata <= word;
              n_words  <= word[15:0];
              wcnt     <= '0;
              state    <= (word[15:0] == '0) ? S_DONE : S_BODY;
            end
          end
          S_BODY: begin
            lw_we    <= 1'b1;
            lw_addr  <= BASE_ADDR + {14'd0, wcnt_nx, 2'b00};
            lw_wdata <= word;
            wcnt     <= wcnt_nx;
            if (wcnt_nx == n_words) state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_run   = run_q;
  assign load_err  = (state == S_ERR);
  assign mem_we    = run_q ? cpu_mem_we    : (lw_we && (state != S_ERR));
  assign mem_addr  = run_q ? cpu_mem_addr  : lw_addr;
  assign mem_wdata = run_q ? cpu_mem_wdata : lw_wdata;
endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Sequences program/data loading into the CPU's data memory from the UART byte stream, then hands the memory port to the CPU and releases it to run. Sits between the UART receiver, the data-memory write port and the CPU core inside the CPU top level. Owns the memory-port arbitration: the loader drives the port during load, the CPU after load.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the header word; word i of the body goes to BASE_ADDR + 4*(i+1)
- MAX_WORDS, 256, maximum body word count accepted
- TIMEOUT_CYCLES, 2_000_000, idle cycles allowed between bytes once loading has started (20 ms at 100 MHz)

Ports:
- sysclk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cpu_mem_we  in  1  CPU data-memory write enable
- cpu_mem_addr  in  32  CPU data-memory address
- cpu_mem_wdata  in  32  CPU data-memory write data
- mem_we  out  1  write enable to data memory
- mem_addr  out  32  address to data memory
- mem_wdata  out  32  write data to data memory
- cpu_run  out  1  level; CPU held in reset while 0
- load_err  out  1  sticky error flag

## Operation
- Frame: header word N (body word count), then N body words. Each word is 4 bytes, most significant byte first.
- States: S_HDR, S_BODY, S_DONE, S_ERR. Reset enters S_HDR with byte index 0, word counter 0 and timeout counter 0.
- S_HDR: assemble 4 bytes.
  - On the 4th byte, write N to BASE_ADDR.
  - If N > MAX_WORDS, go to S_ERR with no write.
  - If N = 0, go to S_DONE.
  - Otherwise go to S_BODY.
- S_BODY: assemble each word and write it to BASE_ADDR + 4*(k+1), where k is the 0-based body index. After word N-1 is written, go to S_DONE.
- S_DONE: cpu_run = 1. mem_* is driven combinationally from cpu_mem_*. rx_valid is ignored.
- S_ERR: load_err = 1 and cpu_run = 0. mem_we = 0. rx_valid is ignored. Only rst leaves this state.
- Timeout: the counter clears on every rx_valid. It increments each cycle when in S_BODY, or in S_HDR with byte index ≠ 0. When it reaches TIMEOUT_CYCLES, go to S_ERR.
- While cpu_run = 0, cpu_mem_* is ignored; the CPU can never write during a load.
- Arithmetic:
  - Word counter is 16 bits and compares against N[15:0].
  - A header with N[31:16] ≠ 0 counts as N > MAX_WORDS.
  - Address = BASE_ADDR + {counter, 2'b00}, computed modulo 2^32.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, cpu_run 0, load_err 0.
- Write latency:
  - 4th byte of a word strobed at cycle t → mem_we = 1 for exactly cycle t+1, with mem_addr and mem_wdata registered.
  - Final body word (or N = 0 header) at t → cpu_run rises at t+2, after the write cycle.
- Back-to-back rx_valid on consecutive cycles is legal. A byte arriving during the write cycle of the previous word is captured as byte 0 of the next word. The assembly register is separate from the write register.
- Simultaneous rx_valid and timeout expiry: rx_valid wins and the counter clears.
- Mid-operation reset: all state is lost and cpu_run drops asynchronously. Loading restarts at the header.
- S_DONE has 0 cycles of added latency on the memory path (pure mux).

## Structure
- Package boot_pkg holds:
  - state enum (S_HDR, S_BODY, S_DONE, S_ERR)
  - BYTES_PER_WORD = 4
  - timeout and word-counter width constants
- Sub-module word_packer, the natural split:
  - shifts bytes in MSB-first
  - 2-bit byte index
  - outputs word_valid pulse plus 32-bit word
- The top level holds the FSM, counters, address generation and the memory-port mux.

## Test plan
- Full frame: header 0x00000014, then 20 words starting 0x000041A8, 0x00003AF2, ending 0x00004955, one byte every 30 baud periods → 21 writes. Body words land at addresses 0x04 through 0x50; header at 0x00; last data 0x00004955 at 0x50; then cpu_run = 1.
- N = 0: header bytes 00 00 00 00 → one write of 0 to 0x00, cpu_run = 1 two cycles after the 4th strobe.
- Oversize: header 0x00000101 with MAX_WORDS = 256 → no write, load_err = 1, cpu_run stays 0, later bytes ignored.
- Timeout: send 2 header bytes, then idle TIMEOUT_CYCLES → load_err = 1. Pulse rst low, then a clean frame loads normally.
- Arbitration: during load, drive cpu_mem_we = 1, addr 0x100 → mem_we follows only loader writes. After cpu_run, cpu_mem_* appears on mem_* in the same cycle.
- Back-to-back: 8 bytes strobed on consecutive cycles for N = 1 → writes on cycles 5 and 9, with correct data and no lost byte.
